// File: rtl/ahb_flash_reader_if.sv
// AHB-Lite slave bus bundle for the flash reader.
interface ahb_flash_reader_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_flash_reader.sv
// AHB-Lite read port onto a quad-SPI flash using Quad I/O Fast Read (0xEB).
// Define AHB_FLASH_READER_BUF_EN to add a one-word read buffer.
module ahb_flash_reader #(
    parameter int DUMMY_CLKS = 4
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_flash_reader_if.slave   ahb,
    output logic                fr_sck,
    output logic                fr_ce_n,
    input  logic [3:0]          fr_din,
    output logic [3:0]          fr_dout,
    output logic                fr_douten
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE} state_t;

    localparam logic [7:0] RD_CMD   = 8'hEB;
    localparam logic [3:0] DUM_LAST = 4'(DUMMY_CLKS - 1);

    state_t      state, nxt;
    logic        half, lead;
    logic [3:0]  cnt, last;
    logic [21:0] addr_q;
    logic [23:0] addr24;
    logic [31:0] rx, rx_nxt, hrdata_q, buf_data;
    logic [4:0]  pos;
    logic        avail, accept, rd_acc, wr_acc, hit, miss, ph_end, frame;

    logic unused_bits;
    assign unused_bits = ^{ahb.HWDATA, ahb.HSIZE, ahb.HADDR[31:24], ahb.HADDR[1:0], ahb.HTRANS[0]};

    assign avail  = (state == IDLE) || (state == DONE);
    assign accept = avail & ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
    assign rd_acc = accept & ~ahb.HWRITE;
    assign wr_acc = accept & ahb.HWRITE;
    assign miss   = rd_acc & ~hit;

    always_comb begin
        last = 4'd0;
        case (state)
            CMD:     last = 4'd7;
            ADDR:    last = 4'd5;
            MODE:    last = 4'd1;
            DUMMY:   last = DUM_LAST;
            DATA:    last = 4'd7;
            default: last = 4'd0;
        endcase
    end

    assign ph_end = ~lead & half & (cnt == last);

    // Nibble j lands in byte j/2, high nibble first.
    assign pos = {cnt[2:1], ~cnt[0], 2'b00};
    always_comb begin
        rx_nxt = rx;
        rx_nxt[pos +: 4] = fr_din;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (miss)   nxt = CMD;
            CMD:     if (ph_end) nxt = ADDR;
            ADDR:    if (ph_end) nxt = MODE;
            MODE:    if (ph_end) nxt = DUMMY;
            DUMMY:   if (ph_end) nxt = DATA;
            DATA:    if (ph_end) nxt = DONE;
            DONE:    nxt = miss ? CMD : IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign addr24 = {addr_q, 2'b00};
    always_comb begin
        frame     = (state != IDLE) && (state != DONE);
        fr_ce_n   = ~frame;
        fr_sck    = frame & half & ~lead;
        fr_douten = (state == CMD) || (state == ADDR) || (state == MODE);
        fr_dout   = 4'h0;
        case (state)
            CMD:     fr_dout = {3'b110, RD_CMD[~cnt[2:0]]};
            ADDR:    fr_dout = addr24[5'(20 - 4 * cnt) +: 4];
            default: fr_dout = 4'h0;
        endcase
    end

    assign ahb.HREADYOUT = ~frame;
    assign ahb.HRDATA    = hrdata_q;
    assign ahb.HRESP     = 1'b0;

    // One leading cycle with CE low and SCK low gives chip-select setup
    // before the first rising edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            half     <= 1'b0;
            lead     <= 1'b0;
            cnt      <= 4'd0;
            addr_q   <= 22'd0;
            rx       <= 32'd0;
            hrdata_q <= 32'd0;
        end else begin
            if (avail) begin
                if (miss) begin
                    addr_q <= ahb.HADDR[23:2];
                    lead   <= 1'b1;
                    half   <= 1'b0;
                    cnt    <= 4'd0;
                end
            end else if (lead) begin
                lead <= 1'b0;
            end else if (!half) begin
                half <= 1'b1;
            end else begin
                half <= 1'b0;
                cnt  <= (cnt == last) ? 4'd0 : cnt + 4'd1;
                if (state == DATA) rx <= rx_nxt;
            end
            if (state == DATA && ph_end) hrdata_q <= rx_nxt;
            else if (hit)                hrdata_q <= buf_data;
        end
    end

`ifdef AHB_FLASH_READER_BUF_EN
    logic [21:0] buf_tag;
    logic        buf_vld;

    assign hit = rd_acc & buf_vld & (buf_tag == ahb.HADDR[23:2]);

    // Filled as the frame completes so a read accepted in DONE can hit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            buf_vld  <= 1'b0;
            buf_tag  <= 22'd0;
            buf_data <= 32'd0;
        end else if (wr_acc) begin
            buf_vld <= 1'b0;
        end else if (state == DATA && ph_end) begin
            buf_vld  <= 1'b1;
            buf_tag  <= addr_q;
            buf_data <= rx_nxt;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = wr_acc;
    assign hit       = 1'b0;
    assign buf_data  = 32'd0;
`endif
endmodule

// File: tb/tb_ahb_flash_reader.sv
// Scoreboard bench for ahb_flash_reader with a behavioural quad-SPI flash.
module tb_ahb_flash_reader;
    localparam int D         = 4;
    localparam int MISS_WAIT = 2 * (24 + D) + 1;
`ifdef AHB_FLASH_READER_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_flash_reader_if bus ();
    logic       fr_sck, fr_ce_n, fr_douten;
    logic [3:0] fr_din, fr_dout;
    assign bus.HREADY = bus.HREADYOUT;

    ahb_flash_reader #(.DUMMY_CLKS(D)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus.slave),
        .fr_sck(fr_sck), .fr_ce_n(fr_ce_n), .fr_din(fr_din),
        .fr_dout(fr_dout), .fr_douten(fr_douten)
    );

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct { bit wr; logic [31:0] data; int waits; } exp_t;
    exp_t        sb[$];
    logic [23:0] fexp[$];
    bit          bvld = 0;
    logic [21:0] btag = '0;
    logic [31:0] last_rd = '0;
    int          frames = 0, exp_frames = 0;

    function automatic logic [7:0] fb(input logic [23:0] a);
        if (a >= 24'h100 && a < 24'h104) return 8'(8'h11 * (a[1:0] + 1));
        return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[3:0], a[23:20]};
    endfunction
    function automatic logic [31:0] word(input logic [23:0] a);
        return {fb(a + 3), fb(a + 2), fb(a + 1), fb(a)};
    endfunction

    // ---------------- flash model ----------------
    int          k;
    bit          in_frame = 0;
    logic [7:0]  cmd, mode;
    logic [23:0] faddr;
    initial fr_din = 4'h0;

    always @(negedge fr_ce_n) begin
        in_frame = 1; k = 0; cmd = 0; mode = 0; faddr = 0; frames++;
    end
    always @(posedge fr_sck) if (in_frame) begin
        chk("douten_phase", 32'(fr_douten), 32'(k < 16));
        if (k < 8) begin
            chk("cmd_io_hi", 32'(fr_dout[3:1]), 32'h6);
            cmd = {cmd[6:0], fr_dout[0]};
        end else if (k < 14) faddr = {faddr[19:0], fr_dout};
        else if (k < 16)     mode  = {mode[3:0], fr_dout};
        else if (k >= 16 + D && k < 24 + D) begin
            int j;
            logic [7:0] b;
            j = k - 16 - D;
            b = fb(faddr + 24'(j / 2));
            fr_din = (j % 2 == 0) ? b[7:4] : b[3:0];
        end
        k++;
    end
    always @(posedge fr_ce_n) if (in_frame) begin
        in_frame = 0;
        if (!HRESETn) begin
            if (fexp.size() != 0) fexp.delete(0);
        end else begin
            chk("cmd_byte", 32'(cmd), 32'hEB);
            chk("mode_byte", 32'(mode), 32'h0);
            chk("frame_clks", 32'(k), 32'(24 + D));
            if (fexp.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
            else chk("flash_addr", 32'(faddr), 32'(fexp.pop_front()));
        end
    end

    // ---------------- pin monitor ----------------
    logic       prev_sck = 0;
    logic [3:0] prev_dout = 0;
    int         hi_run = 0, last_gap = 0;
    always @(negedge HCLK) begin
        if (fr_ce_n) begin
            chk("sck_idle_low", 32'(fr_sck), 32'd0);
            chk("douten_idle", 32'(fr_douten), 32'd0);
            hi_run++;
        end else begin
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
            if (fr_sck && !prev_sck) chk("dout_stable_high", 32'(fr_dout), 32'(prev_dout));
        end
        prev_sck = fr_sck; prev_dout = fr_dout;
    end

    // ---------------- AHB response monitor ----------------
    bit dph = 0;
    int wcnt = 0;
    always @(negedge HCLK) begin
        exp_t e;
        if (!HRESETn) begin
            dph = 0; wcnt = 0;
        end else begin
            if (dph) begin
                if (!bus.HREADYOUT) wcnt++;
                else begin
                    if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk(e.wr ? "wr_waits" : "rd_waits", 32'(wcnt), 32'(e.waits));
                        chk(e.wr ? "wr_hrdata" : "rd_hrdata", bus.HRDATA, e.data);
                        chk("hresp", 32'(bus.HRESP), 32'd0);
                    end
                    dph = 0; wcnt = 0;
                end
            end
            if (bus.HSEL && bus.HTRANS[1] && bus.HREADYOUT) begin
                dph = 1; wcnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit wr, input logic [31:0] addr);
        exp_t e;
        int t;
        logic [23:0] wa;
        wa = {addr[23:2], 2'b00};
        e.wr = wr; e.waits = 0; e.data = last_rd;
        if (wr) bvld = 0;
        else begin
            e.data = word(wa);
            last_rd = e.data;
            if (!(BUF && bvld && btag == addr[23:2])) begin
                e.waits = MISS_WAIT;
                fexp.push_back(wa);
                exp_frames++;
                if (BUF) begin bvld = 1; btag = addr[23:2]; end
            end
        end
        sb.push_back(e);
        bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = wr;
        bus.HSIZE = 3'b010; bus.HWDATA = $urandom;
        t = 0;
        @(negedge HCLK);
        while (!bus.HREADYOUT && t < 300) begin @(negedge HCLK); t++; end
        if (t >= 300) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge HCLK); #1;
    endtask

    task automatic idle();
        bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HWRITE = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin @(posedge HCLK); t++; end
        if (t >= 500) chk("drain_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
    endtask

    initial begin
        int f0, n, t;
        idle(); bus.HADDR = 0; bus.HSIZE = 3'b010; bus.HWDATA = 0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_ce_n", 32'(fr_ce_n), 32'd1);
        chk("rst_sck", 32'(fr_sck), 32'd0);
        chk("rst_douten", 32'(fr_douten), 32'd0);
        chk("rst_dout", 32'(fr_dout), 32'd0);
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_hrdata", bus.HRDATA, 32'd0);
        @(negedge HCLK); HRESETn = 1;
        @(posedge HCLK); #1;

        issue(0, 32'h0000_0100); idle(); drain();

        f0 = frames;
        issue(1, 32'h0000_0000); idle(); drain();
        chk("wr_no_frame", 32'(frames), 32'(f0));

        issue(0, 32'h0000_0000); issue(0, 32'h0000_0004); idle(); drain();
        chk("ce_gap_b2b", 32'(last_gap), 32'd1);

        issue(0, 32'h0000_0010); idle(); drain();
        f0 = frames;
        issue(0, 32'h0000_0010); idle(); drain();
        chk("reread_frames", 32'(frames - f0), BUF ? 32'd0 : 32'd1);
        issue(1, 32'h0000_0010); issue(0, 32'h0000_0010); idle(); drain();

        // reset during the fourth data nibble
        issue(0, 32'h0000_0200); idle();
        n = 0; t = 0;
        while (n < 16 + D + 4 && t < 200) begin
            @(posedge HCLK); #2;
            if (fr_sck) n++;
            t++;
        end
        if (t >= 200) chk("nibble_wait_timeout", 32'd1, 32'd0);
        HRESETn = 0;
        #1;
        chk("mid_rst_ce_n", 32'(fr_ce_n), 32'd1);
        chk("mid_rst_sck", 32'(fr_sck), 32'd0);
        chk("mid_rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("mid_rst_douten", 32'(fr_douten), 32'd0);
        chk("mid_rst_hrdata", bus.HRDATA, 32'd0);
        sb.delete(); bvld = 0; last_rd = 0;
        @(negedge HCLK); @(negedge HCLK); HRESETn = 1;
        @(posedge HCLK); #1;
        issue(1, 32'h0000_0008); issue(0, 32'h0000_0100); idle(); drain();

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = 32'h0000_0010;
                1:       a = 32'h0000_0100;
                2:       a = $urandom;
                default: a = 32'hFF00_0014;
            endcase
            issue($urandom_range(0, 3) == 0, a);
            if ($urandom_range(0, 1) == 1) begin
                idle();
                repeat ($urandom_range(0, 3)) @(posedge HCLK);
                #1;
            end
        end
        idle(); drain();

        chk("total_frames", 32'(frames), 32'(exp_frames));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("fexp_empty", 32'(fexp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        chk("global_timeout", 32'd1, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ahb_flash_reader.md
AHB_FLASH_READER -- requirements
Module: ahb_flash_reader

Interface
REQ-001 SHALL have parameter DUMMY_CLKS, default 4, number of SPI dummy clocks after the mode byte (legal 1..15).
REQ-002 SHALL have port HCLK, input, 1, clock.
REQ-003 SHALL have port HRESETn, input, 1, reset (asynchronous, active-low).
REQ-004 SHALL have AHB-Lite slave inputs:
- HSEL 1
- HADDR 32
- HTRANS 2
- HWRITE 1
- HSIZE 3
- HWDATA 32
- HREADY 1
REQ-005 SHALL have AHB-Lite slave outputs HREADYOUT 1, HRDATA 32 and HRESP 1.
REQ-006 SHALL have flash-side ports, feeding the flash-writer mux:
- fr_sck output 1, SPI clock
- fr_ce_n output 1, chip select
- fr_din input 4, IO0..IO3 from flash
- fr_dout output 4, IO0..IO3 to flash
- fr_douten output 1, drive enable for fr_dout

Function
REQ-007 SHALL accept a transfer when HSEL & HTRANS[1] & HREADY are high at a rising HCLK edge (address phase); the address is registered at that edge.
REQ-008 SHALL complete writes with zero wait states and OKAY response; write data is discarded.
REQ-009 SHALL drive HRESP 0 always.
REQ-010 SHALL service reads with a Quad I/O Fast Read (0xEB) of the word at {HADDR[23:2],2'b00}; HADDR[31:24], HADDR[1:0] and HSIZE are ignored.
REQ-011 SHALL use FSM states IDLE, CMD (8 SPI clks), ADDR (6), MODE (2), DUMMY (DUMMY_CLKS), DATA (8), DONE (1 HCLK).
REQ-012 SHALL move IDLE->CMD on an accepted read.
REQ-013 SHALL advance CMD->ADDR->MODE->DUMMY->DATA->DONE on phase-count expiry.
REQ-014 SHALL move DONE->CMD if a read is accepted in DONE, DONE->IDLE otherwise.
REQ-015 SHALL make each SPI clock 2 HCLK cycles, fr_sck low then high.
REQ-016 SHALL change fr_dout only while fr_sck is low.
REQ-017 SHALL sample fr_din on the HCLK edge ending each high half-period of fr_sck.
REQ-018 SHALL hold fr_ce_n low in CMD through DATA and high in IDLE and DONE.
REQ-019 SHALL hold fr_sck low whenever fr_ce_n is high.
REQ-020 SHALL, in CMD, send command bits MSB first on IO0 with fr_dout = {1,1,0,bit}.
REQ-021 SHALL, in ADDR, send 24 address bits, nibble-wise MSB first.
REQ-022 SHALL, in MODE, send 0x00 (no continuous-read mode).
REQ-023 SHALL assert fr_douten in CMD, ADDR and MODE and deassert it in all other states.
REQ-024 SHALL, in DATA, assemble 8 nibbles into a little-endian word: first byte to HRDATA[7:0], high nibble first in each byte.
REQ-025 SHALL drive HREADYOUT low from the cycle after read acceptance through the last DATA cycle and high in DONE with HRDATA valid; wait states = 2*(24+DUMMY_CLKS)+1 (57 at default).
REQ-026 SHALL hold HRDATA stable outside DONE at the last fetched word.
REQ-027 SHALL ignore HTRANS while HREADYOUT is low.
REQ-028 SHALL accept a back-to-back read in DONE with no extra idle cycle; fr_ce_n is high for exactly 1 HCLK between frames.

Reset
REQ-029 SHALL, on HRESETn low (including mid-frame), force state IDLE, fr_ce_n 1, fr_sck 0, fr_douten 0, fr_dout 0, HREADYOUT 1, HRDATA 0 and all counters 0, asynchronously.
REQ-030 SHALL resume normal operation on the first accepted read after reset release.

Configuration
REQ-031 SHALL, with AHB_FLASH_READER_BUF_EN defined, hold a one-word buffer (data, 22-bit tag HADDR[23:2], valid bit).
REQ-032 SHALL, with the buffer compiled in, complete a hit read (valid and tag match) with zero wait states and no flash frame.
REQ-033 SHALL, with the buffer compiled in, fill the buffer from a miss read in DONE.
REQ-034 SHALL, with the buffer compiled in, clear valid on reset and on any accepted write.
REQ-035 SHALL, without AHB_FLASH_READER_BUF_EN, contain no buffer and run every read as a full flash frame.

Verification
REQ-036 SHALL cover: read 0x000100 with flash model bytes 11 22 33 44 -> HRDATA 0x44332211 after exactly 57 wait states, fr_dout 0xEB on IO0 then address nibbles 0,0,0,1,0,0.
REQ-037 SHALL cover: write to 0x0 -> zero wait, OKAY, fr_ce_n stays 1.
REQ-038 SHALL cover: two back-to-back reads 0x0, 0x4 -> fr_ce_n high for 1 HCLK between frames, both words correct.
REQ-039 SHALL cover: HRESETn low during DATA nibble 3 -> fr_ce_n 1, fr_sck 0, HREADYOUT 1 immediately; the next read returns correct data.
REQ-040 SHALL cover, with BUF_EN: read 0x10 twice -> second read zero wait, no fr_ce_n activity; write, then read 0x10 -> full 57-wait frame.
